sccb_slave: RTL and testbench

- Synthesizable SCCB responder: the camera-side end of the two-wire SCCB bus.
- Decodes 3-phase write, 2-phase write (sets the address pointer) and 2-phase read transactions from an SCCB master. Issues single-cycle register write/read strobes to an external register bank.
- Serves as an OV7670 stand-in in board-level loopback tests of the initialisation path, and as a reusable register-access slave.

---
 rtl/sccb_pkg.sv | 27 ++
 rtl/sccb_bus_sync.sv | 47 ++++
 rtl/sccb_slave.sv | 210 +++++++++++++++++++++
 tb/tb_sccb_slave.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB responder: FSM encoding, the OV7670
// device address and byte/phase constants.
package sccb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV,
        ST_DEV_ACK,
        ST_SUB,
        ST_SUB_ACK,
        ST_WR,
        ST_WR_ACK,
        ST_RD,
        ST_RD_NA,
        ST_IGNORE
    } sccb_state_t;

    localparam logic [7:0] OV7670_ID = 8'h42;
    localparam logic [2:0] LAST_BIT  = 3'd7;
    localparam logic       RW_READ   = 1'b1;

    // Device address compare ignores the R/W bit in position 0.
    function automatic logic id_match(input logic [7:0] rx, input logic [7:0] id);
        return ((rx ^ id) & 8'hFE) == 8'h00;
    endfunction

endpackage

// File: rtl/sccb_bus_sync.sv
// Brings sio_c / sio_d into the sclk domain and flags SCL edges plus
// START/STOP conditions (SDA edges with SCL steady high).
module sccb_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic sclk,
    input  logic rst_n,
    input  logic sio_c,
    input  logic sio_d_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic                   w_scl_s;

    // Reset to the idle bus level so release from reset creates no events.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], sio_c};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sio_d_i};
            r_scl_d    <= w_scl_s;
            r_sda_d    <= sda_s;
        end
    end

    assign w_scl_s = r_scl_sync[SYNC_STAGES-1];
    assign sda_s   = r_sda_sync[SYNC_STAGES-1];

    assign scl_rise  = w_scl_s & ~r_scl_d;
    assign scl_fall  = ~w_scl_s & r_scl_d;
    // SCL must be high in both samples; an SDA edge coinciding with an SCL edge is data.
    assign start_det = w_scl_s & r_scl_d & r_sda_d & ~sda_s;
    assign stop_det  = w_scl_s & r_scl_d & ~r_sda_d & sda_s;

endmodule

// File: rtl/sccb_slave.sv
// SCCB responder: decodes 3-phase write, 2-phase write and 2-phase read
// transactions and issues single-cycle strobes to an external register bank.
module sccb_slave
    import sccb_pkg::*;
#(
    parameter logic [7:0] DEV_ID      = OV7670_ID,
    parameter int         ACK_EN      = 1,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic       sio_c,
    input  logic       sio_d_i,
    output logic       sio_d_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       id_err,
    output logic       frame_done
);

    logic        w_scl_rise;
    logic        w_scl_fall;
    logic        w_start;
    logic        w_stop;
    logic        w_sda_s;
    logic [7:0]  w_byte;
    logic        w_byte_done;

    sccb_state_t r_state;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_ack_open;
    logic        r_rd_dir;
    logic        r_ld_pend;
    logic        r_drv_pend;
    logic        r_sio_d_oe;
    logic [7:0]  r_reg_addr;
    logic [7:0]  r_reg_wdata;
    logic        r_reg_we;
    logic        r_reg_re;
    logic        r_busy;
    logic        r_id_err;
    logic        r_frame_done;

    sccb_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .sio_c     (sio_c),
        .sio_d_i   (sio_d_i),
        .scl_rise  (w_scl_rise),
        .scl_fall  (w_scl_fall),
        .start_det (w_start),
        .stop_det  (w_stop),
        .sda_s     (w_sda_s)
    );

    assign w_byte      = {r_shift[6:0], w_sda_s};
    assign w_byte_done = w_scl_rise && (r_bit_cnt == LAST_BIT);

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'h00;
            r_ack_open   <= 1'b0;
            r_rd_dir     <= 1'b0;
            r_ld_pend    <= 1'b0;
            r_drv_pend   <= 1'b0;
            r_sio_d_oe   <= 1'b0;
            r_reg_addr   <= 8'h00;
            r_reg_wdata  <= 8'h00;
            r_reg_we     <= 1'b0;
            r_reg_re     <= 1'b0;
            r_busy       <= 1'b0;
            r_id_err     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_reg_we     <= 1'b0;
            r_reg_re     <= 1'b0;
            r_id_err     <= 1'b0;
            r_frame_done <= 1'b0;
            r_ld_pend    <= 1'b0;

            if (w_start) begin
                r_state    <= ST_DEV;
                r_bit_cnt  <= 3'd0;
                r_sio_d_oe <= 1'b0;
                r_busy     <= 1'b1;
                r_ack_open <= 1'b0;
                r_drv_pend <= 1'b0;
            end else if (w_stop && (r_state != ST_IDLE)) begin
                r_state      <= ST_IDLE;
                r_sio_d_oe   <= 1'b0;
                r_busy       <= 1'b0;
                r_frame_done <= 1'b1;
                r_drv_pend   <= 1'b0;
            end else begin
                // Read pipeline: strobe -> load shifter from bank -> drive MSB.
                r_ld_pend <= r_reg_re && (r_state == ST_RD);
                if (r_ld_pend) begin
                    r_shift    <= reg_rdata;
                    r_drv_pend <= 1'b1;
                end
                if (r_drv_pend) begin
                    r_sio_d_oe <= ~r_shift[7];
                    r_drv_pend <= 1'b0;
                end

                case (r_state)
                    ST_IDLE: ;

                    ST_DEV, ST_SUB, ST_WR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                        if (w_byte_done) begin
                            r_ack_open <= 1'b0;
                            case (r_state)
                                ST_DEV: begin
                                    if (id_match(w_byte, DEV_ID)) begin
                                        r_rd_dir <= (w_byte[0] == RW_READ);
                                        r_state  <= ST_DEV_ACK;
                                    end else begin
                                        r_id_err <= 1'b1;
                                        r_state  <= ST_IGNORE;
                                    end
                                end
                                ST_SUB: begin
                                    r_reg_addr <= w_byte;
                                    r_state    <= ST_SUB_ACK;
                                end
                                default: begin
                                    r_reg_wdata <= w_byte;
                                    r_reg_we    <= 1'b1;
                                    r_state     <= ST_WR_ACK;
                                end
                            endcase
                        end
                    end

                    // First fall opens the 9th-bit slot, second fall closes it.
                    ST_DEV_ACK, ST_SUB_ACK, ST_WR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_open) begin
                                r_sio_d_oe <= (ACK_EN != 0);
                                r_ack_open <= 1'b1;
                            end else begin
                                r_sio_d_oe <= 1'b0;
                                r_ack_open <= 1'b0;
                                r_bit_cnt  <= 3'd0;
                                case (r_state)
                                    ST_DEV_ACK: begin
                                        if (r_rd_dir) begin
                                            r_reg_re <= 1'b1;
                                            r_state  <= ST_RD;
                                        end else begin
                                            r_state  <= ST_SUB;
                                        end
                                    end
                                    ST_SUB_ACK: r_state <= ST_WR;
                                    default:    r_state <= ST_IGNORE;
                                endcase
                            end
                        end
                    end

                    ST_RD: begin
                        if (w_scl_fall) begin
                            if (r_bit_cnt == LAST_BIT) begin
                                r_sio_d_oe <= 1'b0;
                                r_state    <= ST_RD_NA;
                            end else begin
                                r_shift    <= {r_shift[6:0], 1'b0};
                                r_sio_d_oe <= ~r_shift[6];
                                r_bit_cnt  <= r_bit_cnt + 3'd1;
                            end
                        end
                    end

                    ST_RD_NA: begin
                        if (w_scl_rise) begin
                            r_state <= ST_IGNORE;
                        end
                    end

                    ST_IGNORE: r_sio_d_oe <= 1'b0;

                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign sio_d_oe   = r_sio_d_oe;
    assign reg_addr   = r_reg_addr;
    assign reg_wdata  = r_reg_wdata;
    assign reg_we     = r_reg_we;
    assign reg_re     = r_reg_re;
    assign busy       = r_busy;
    assign id_err     = r_id_err;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_sccb_slave.sv
// Directed bench for sccb_slave: a bit-banged SCCB master on an open-drain
// SIO_D line, a one-register read model and pulse counters.
module tb_sccb_slave;

    localparam int Q = 8;

    logic       sclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_line;
    logic       sio_d_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy;
    logic       id_err;
    logic       frame_done;

    logic [7:0] rd_value = 8'h00;
    int n_checks = 0;
    int n_errors = 0;
    int we_cnt = 0, re_cnt = 0, iderr_cnt = 0, fd_cnt = 0;
    logic [7:0] we_addr = 8'h00, we_data = 8'h00, re_addr = 8'h00;

    assign sda_line = m_sda & ~sio_d_oe;

    always #10 sclk = ~sclk;

    sccb_slave dut (
        .sclk       (sclk),
        .rst_n      (rst_n),
        .sio_c      (scl),
        .sio_d_i    (sda_line),
        .sio_d_oe   (sio_d_oe),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .reg_re     (reg_re),
        .reg_rdata  (reg_rdata),
        .busy       (busy),
        .id_err     (id_err),
        .frame_done (frame_done)
    );

    // Register bank model: data valid the cycle after the read strobe.
    always @(posedge sclk) if (reg_re) reg_rdata <= rd_value;

    always @(negedge sclk) begin
        if (reg_we) begin we_cnt++; we_addr = reg_addr; we_data = reg_wdata; end
        if (reg_re) begin re_cnt++; re_addr = reg_addr; end
        if (id_err) iderr_cnt++;
        if (frame_done) fd_cnt++;
    end

    typedef struct {
        logic [3:0][7:0] bytes;
        int              nbytes;
        int              exp_we;
        logic [7:0]      exp_addr;
        logic [7:0]      exp_data;
        int              exp_iderr;
        logic [3:0]      exp_ack;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(posedge sclk);
        #1;
    endtask

    task automatic clock_bit(input logic b, output logic line_s, output logic oe_s);
        m_sda = b;
        wait_q();
        scl = 1'b1;
        wait_q();
        line_s = sda_line;
        oe_s   = sio_d_oe;
        wait_q();
        scl = 1'b0;
        wait_q();
    endtask

    task automatic start_cond();
        m_sda = 1'b1; wait_q();
        scl = 1'b1;   wait_q();
        m_sda = 1'b0; wait_q();
        scl = 1'b0;   wait_q();
    endtask

    task automatic stop_cond();
        m_sda = 1'b0; wait_q();
        scl = 1'b1;   wait_q();
        m_sda = 1'b1; wait_q();
        wait_q();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack_oe);
        logic l, o;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], l, o);
        clock_bit(1'b1, l, ack_oe);
    endtask

    task automatic read_byte(output logic [7:0] d, output logic na_oe);
        logic l, o;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, l, o);
            d = {d[6:0], l};
        end
        clock_bit(1'b1, l, na_oe);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int we0, id0, fd0;
        logic [3:0] ack;
        logic a;
        we0 = we_cnt; id0 = iderr_cnt; fd0 = fd_cnt; ack = 4'b0000;
        start_cond();
        check({tag, "_busy_start"}, busy, 1);
        for (int i = 0; i < v.nbytes; i++) begin
            send_byte(v.bytes[i], a);
            ack[i] = a;
        end
        check({tag, "_busy_pre_stop"}, busy, 1);
        stop_cond();
        check({tag, "_ack_mask"}, ack, v.exp_ack);
        check({tag, "_we_count"}, we_cnt - we0, v.exp_we);
        if (v.exp_we > 0) begin
            check({tag, "_we_addr"}, we_addr, v.exp_addr);
            check({tag, "_we_data"}, we_data, v.exp_data);
        end
        check({tag, "_id_err"}, iderr_cnt - id0, v.exp_iderr);
        check({tag, "_frame_done"}, fd_cnt - fd0, 1);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_reg_addr"}, reg_addr, v.exp_addr);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic a, na;
        int re0, we0, fd0;
        vec_t rs;

        vecs[0] = '{bytes: {8'h00, 8'h80, 8'h12, 8'h42}, nbytes: 3, exp_we: 1,
                    exp_addr: 8'h12, exp_data: 8'h80, exp_iderr: 0, exp_ack: 4'b0111};
        vecs[1] = '{bytes: {8'h00, 8'h80, 8'h12, 8'h60}, nbytes: 3, exp_we: 0,
                    exp_addr: 8'h12, exp_data: 8'h00, exp_iderr: 1, exp_ack: 4'b0000};
        vecs[2] = '{bytes: {8'h55, 8'h01, 8'h11, 8'h42}, nbytes: 4, exp_we: 1,
                    exp_addr: 8'h11, exp_data: 8'h01, exp_iderr: 0, exp_ack: 4'b0111};
        vecs[3] = '{bytes: {8'h00, 8'h00, 8'h0A, 8'h42}, nbytes: 2, exp_we: 0,
                    exp_addr: 8'h0A, exp_data: 8'h00, exp_iderr: 0, exp_ack: 4'b0011};

        repeat (5) @(posedge sclk);
        #1;
        check("rst_oe", sio_d_oe, 0);
        check("rst_addr", reg_addr, 0);
        check("rst_wdata", reg_wdata, 0);
        check("rst_we", reg_we, 0);
        check("rst_re", reg_re, 0);
        check("rst_busy", busy, 0);
        check("rst_id_err", id_err, 0);
        check("rst_frame_done", frame_done, 0);
        rst_n = 1'b1;
        wait_q();

        run_vec(vecs[0], "wr3");
        run_vec(vecs[1], "badid");
        run_vec(vecs[2], "wr4");
        run_vec(vecs[3], "wr2");

        // Read back after the 2-phase pointer write.
        rd_value = 8'h76;
        re0 = re_cnt; we0 = we_cnt; fd0 = fd_cnt;
        start_cond();
        send_byte(8'h43, a);
        check("rd_dev_ack", a, 1);
        read_byte(d, na);
        stop_cond();
        check("rd_data", d, 8'h76);
        check("rd_na_oe", na, 0);
        check("rd_re_count", re_cnt - re0, 1);
        check("rd_re_addr", re_addr, 8'h0A);
        check("rd_we_count", we_cnt - we0, 0);
        check("rd_frame_done", fd_cnt - fd0, 1);

        // Repeated START after half a sub-address byte.
        we0 = we_cnt;
        start_cond();
        send_byte(8'h42, a);
        clock_bit(1'b1, a, na);
        clock_bit(1'b0, a, na);
        clock_bit(1'b1, a, na);
        clock_bit(1'b1, a, na);
        rs = '{bytes: {8'h00, 8'h04, 8'h3A, 8'h42}, nbytes: 3, exp_we: 1,
               exp_addr: 8'h3A, exp_data: 8'h04, exp_iderr: 0, exp_ack: 4'b0111};
        run_vec(rs, "rstart");
        check("rstart_total_we", we_cnt - we0, 1);

        // Asynchronous reset while the slave drives a read bit low.
        rd_value = 8'h00;
        start_cond();
        send_byte(8'h43, a);
        for (int i = 0; i < 3; i++) clock_bit(1'b1, a, na);
        check("arst_pre_oe", sio_d_oe, 1);
        @(posedge sclk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_oe", sio_d_oe, 0);
        check("arst_busy", busy, 0);
        check("arst_addr", reg_addr, 0);
        repeat (3) @(posedge sclk);
        #1;
        rst_n = 1'b1;
        m_sda = 1'b1;
        wait_q();
        scl = 1'b1;
        wait_q();
        wait_q();
        run_vec(vecs[0], "post_rst_wr3");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
